// File: rtl/pac_pkg.sv
// pac_pkg: direction and FSM state types, grid limits and the opposite() helper
package pac_pkg;
    typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} dir_t;
    typedef enum logic {AT_CELL = 1'b0, IN_STEP = 1'b1} state_t;
    localparam logic [4:0] GRID_MAX_X = 5'd13;
    localparam logic [4:0] GRID_MAX_Y = 5'd13;
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction
endpackage

// File: rtl/pac_neighbor.sv
// pac_neighbor: cell one step away in a direction; PAC_TUNNEL_EN adds the X=0 <-> X=13 wrap
module pac_neighbor
    import pac_pkg::*;
(
    input  logic [4:0] x,
    input  logic [4:0] y,
    input  logic [1:0] dir,
    output logic [4:0] nx,
    output logic [4:0] ny
);
`ifdef PAC_TUNNEL_EN
    localparam bit TUNNEL = 1'b1;
`else
    localparam bit TUNNEL = 1'b0;
`endif
    assign ny = dir == UP ? y - 5'd1 : dir == DOWN ? y + 5'd1 : y;
    assign nx = dir == LEFT  ? (TUNNEL && x == 5'd0 ? GRID_MAX_X : x - 5'd1) :
                dir == RIGHT ? (TUNNEL && x == GRID_MAX_X ? 5'd0 : x + 5'd1) : x;
endmodule

// File: rtl/pac_mover.sv
// pac_mover: cell-by-cell sprite mover with buffered turns and mid-step reversal
// PAC_TUNNEL_EN: column 0 always opens leftward and wraps to column 13 (and back)
module pac_mover
    import pac_pkg::*;
#(
    parameter logic [4:0] START_X  = 5'd6,
    parameter logic [4:0] START_Y  = 5'd9,
    parameter int         CELL_PIX = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic       dir_req_valid,
    input  logic [1:0] dir_req,
    input  logic       check_left,
    input  logic       check_right,
    input  logic       check_up,
    input  logic       check_down,
    output logic [4:0] query_X,
    output logic [4:0] query_Y,
    output logic [4:0] cell_X,
    output logic [4:0] cell_Y,
    output logic [3:0] sub_off,
    output logic [1:0] facing,
    output logic       moving,
    output logic       step_done
);
    localparam logic [3:0] LAST = 4'(CELL_PIX - 1);
    localparam logic [4:0] PIX  = 5'(CELL_PIX);
    state_t     state, state_nxt;
    dir_t       face_q, face_n, pend_dir, pend_dir_n;
    logic       pend_vld, pend_vld_n, mov_n, done_n;
    logic [4:0] cx_n, cy_n, nb_x, nb_y;
    logic [3:0] sub_n, chk;
    logic       go, tun_left, take_pend, cont, rev, last;

    pac_neighbor u_nb (
        .x  (cell_X),
        .y  (cell_Y),
        .dir(face_q),
        .nx (nb_x),
        .ny (nb_y)
    );

`ifdef PAC_TUNNEL_EN
    assign tun_left = cell_X == 5'd0;
`else
    assign tun_left = 1'b0;
`endif

    assign query_X   = cell_X;
    assign query_Y   = cell_Y;
    assign facing    = face_q;
    assign go        = frame_tick & enable;
    assign chk       = {check_right, check_left | tun_left, check_down, check_up};
    assign take_pend = pend_vld & chk[pend_dir];
    assign cont      = moving & chk[face_q];
    assign rev       = pend_vld & (pend_dir == opposite(face_q));
    assign last      = sub_off == LAST;

    always_ff @(posedge Clk) begin
        if (Reset) state <= AT_CELL;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (go && state == AT_CELL && (take_pend || cont)) state_nxt = IN_STEP;
        else if (go && state == IN_STEP && !rev && last)   state_nxt = AT_CELL;
    end

    // Tick handling happens before the request load, so a same-cycle request waits for the next tick
    always_comb begin
        cx_n       = cell_X;
        cy_n       = cell_Y;
        sub_n      = sub_off;
        face_n     = face_q;
        mov_n      = moving;
        pend_vld_n = pend_vld;
        pend_dir_n = pend_dir;
        done_n     = 1'b0;
        if (go && state == AT_CELL) begin
            if (take_pend) begin
                face_n     = pend_dir;
                pend_vld_n = 1'b0;
                sub_n      = 4'd1;
                mov_n      = 1'b1;
            end else if (cont) begin
                sub_n = 4'd1;
            end else begin
                mov_n = 1'b0;
            end
        end else if (go) begin
            if (rev) begin
                // Re-anchor on the cell ahead so sub_off stays measured toward the new facing
                cx_n       = nb_x;
                cy_n       = nb_y;
                sub_n      = 4'(PIX - {1'b0, sub_off});
                face_n     = opposite(face_q);
                pend_vld_n = 1'b0;
            end else if (last) begin
                cx_n   = nb_x;
                cy_n   = nb_y;
                sub_n  = 4'd0;
                done_n = 1'b1;
            end else begin
                sub_n = sub_off + 4'd1;
            end
        end
        if (enable && dir_req_valid) begin
            pend_vld_n = 1'b1;
            pend_dir_n = dir_t'(dir_req);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cell_X    <= START_X;
            cell_Y    <= START_Y;
            sub_off   <= 4'd0;
            face_q    <= LEFT;
            moving    <= 1'b0;
            pend_vld  <= 1'b0;
            pend_dir  <= LEFT;
            step_done <= 1'b0;
        end else begin
            cell_X    <= cx_n;
            cell_Y    <= cy_n;
            sub_off   <= sub_n;
            face_q    <= face_n;
            moving    <= mov_n;
            pend_vld  <= pend_vld_n;
            pend_dir  <= pend_dir_n;
            step_done <= done_n;
        end
    end
endmodule

// File: tb/tb_pac_mover.sv
// tb_pac_mover: directed scenarios plus random stimulus against a behavioural mover model
module tb_pac_mover;
    logic       Clk = 1'b0, Reset = 1'b1, frame_tick = 1'b0, enable = 1'b0, dir_req_valid = 1'b0;
    logic [1:0] dir_req = 2'd0;
    logic       check_left = 1'b0, check_right = 1'b0, check_up = 1'b0, check_down = 1'b0;
    logic [4:0] query_X, query_Y, cell_X, cell_Y;
    logic [3:0] sub_off;
    logic [1:0] facing;
    logic       moving, step_done;
    int         n_checks = 0, n_err = 0, done_cnt = 0, done_base;

`ifdef PAC_TUNNEL_EN
    localparam bit TUN = 1'b1;
`else
    localparam bit TUN = 1'b0;
`endif

    pac_mover dut (
        .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .enable(enable),
        .dir_req_valid(dir_req_valid), .dir_req(dir_req),
        .check_left(check_left), .check_right(check_right), .check_up(check_up), .check_down(check_down),
        .query_X(query_X), .query_Y(query_Y), .cell_X(cell_X), .cell_Y(cell_Y),
        .sub_off(sub_off), .facing(facing), .moving(moving), .step_done(step_done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Model: sub offset 0 means parked on a cell, anything else means mid-step
    logic [4:0] m_x, m_y;
    logic [3:0] m_sub;
    logic [1:0] m_face, m_pd;
    logic       m_mov, m_pv, m_done, m_init = 1'b0;

    function automatic bit legal(input logic [1:0] d, input logic [4:0] x);
        logic [3:0] c;
        c = {check_right, check_left, check_down, check_up};
        return c[d] || (TUN && d == 2'd2 && x == 5'd0);
    endfunction

    function automatic logic [9:0] step(input logic [4:0] x, input logic [4:0] y, input logic [1:0] d);
        case (d)
            2'd0:    return {x, y - 5'd1};
            2'd1:    return {x, y + 5'd1};
            2'd2:    return {(TUN && x == 5'd0) ? 5'd13 : x - 5'd1, y};
            default: return {(TUN && x == 5'd13) ? 5'd0 : x + 5'd1, y};
        endcase
    endfunction

    always @(posedge Clk) begin : model
        logic [4:0] x, y;
        logic [3:0] s;
        logic [1:0] f, pd;
        logic       mv, pv, dn;
        x = m_x; y = m_y; s = m_sub; f = m_face; pd = m_pd; mv = m_mov; pv = m_pv; dn = 1'b0;
        if (Reset) begin
            x = 5'd6; y = 5'd9; s = 4'd0; f = 2'd2; mv = 1'b0; pv = 1'b0;
        end else begin
            if (enable && frame_tick) begin
                if (s == 4'd0) begin
                    if (pv && legal(pd, x)) begin
                        f = pd; pv = 1'b0; s = 4'd1; mv = 1'b1;
                    end else if (mv && legal(f, x)) s = 4'd1;
                    else mv = 1'b0;
                end else if (pv && pd == (f ^ 2'd1)) begin
                    {x, y} = step(x, y, f);
                    s = 4'(16 - int'(s));
                    f = f ^ 2'd1;
                    pv = 1'b0;
                end else if (s == 4'd15) begin
                    {x, y} = step(x, y, f);
                    s = 4'd0;
                    dn = 1'b1;
                end else s = s + 4'd1;
            end
            if (enable && dir_req_valid) begin
                pv = 1'b1; pd = dir_req;
            end
        end
        m_x <= x; m_y <= y; m_sub <= s; m_face <= f; m_pd <= pd; m_mov <= mv; m_pv <= pv; m_done <= dn;
        m_init <= m_init | Reset;
    end

    always @(negedge Clk) begin
        if (step_done) done_cnt <= done_cnt + 1;
        if (m_init) begin
            chk("m_cell_X", cell_X, m_x);
            chk("m_cell_Y", cell_Y, m_y);
            chk("m_query_X", query_X, m_x);
            chk("m_query_Y", query_Y, m_y);
            chk("m_sub_off", sub_off, m_sub);
            chk("m_facing", facing, m_face);
            chk("m_moving", moving, m_mov);
            chk("m_step_done", step_done, m_done);
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            cyc();
        end
        frame_tick = 1'b0;
    endtask

    task automatic req(input logic [1:0] d);
        dir_req_valid = 1'b1;
        dir_req = d;
        cyc();
        dir_req_valid = 1'b0;
    endtask

    initial begin
        cyc(); cyc();
        Reset = 1'b0;
        enable = 1'b1;
        chk("rst_cell_X", cell_X, 6);
        chk("rst_cell_Y", cell_Y, 9);
        chk("rst_facing", facing, 2);
        chk("rst_moving", moving, 0);
        chk("rst_step_done", step_done, 0);
        tick(5);
        chk("blocked_cell_X", cell_X, 6);
        chk("blocked_moving", moving, 0);
        chk("blocked_sub", sub_off, 0);
        done_base = done_cnt;
        check_right = 1'b1;
        req(2'd3);
        tick(16);
        chk("right_cell_X", cell_X, 7);
        chk("right_cell_Y", cell_Y, 9);
        chk("right_sub", sub_off, 0);
        cyc();
        chk("right_done_pulses", done_cnt - done_base, 1);
        tick(5);
        chk("pre_rev_sub", sub_off, 5);
        req(2'd2);
        tick(1);
        chk("rev_cell_X", cell_X, 8);
        chk("rev_sub", sub_off, 11);
        chk("rev_facing", facing, 2);
        check_right = 1'b0;
        tick(5);
        chk("rev_back_X", cell_X, 7);
        chk("rev_back_sub", sub_off, 0);
        check_right = 1'b1;
        req(2'd3);
        tick(1);
        chk("turn_right_facing", facing, 3);
        req(2'd0);
        tick(15);
        tick(1);
        chk("blocked_up_facing", facing, 3);
        chk("blocked_up_sub", sub_off, 1);
        tick(15);
        chk("at_9_9_X", cell_X, 9);
        check_up = 1'b1;
        tick(1);
        chk("turn_up_facing", facing, 0);
        chk("turn_up_sub", sub_off, 1);
        tick(2);
        enable = 1'b0;
        repeat (10) begin
            frame_tick = 1'b1; dir_req_valid = 1'b1; dir_req = 2'd1;
            cyc();
        end
        frame_tick = 1'b0; dir_req_valid = 1'b0;
        chk("frozen_cell_X", cell_X, 9);
        chk("frozen_cell_Y", cell_Y, 9);
        chk("frozen_sub", sub_off, 3);
        chk("frozen_facing", facing, 0);
        chk("frozen_moving", moving, 1);
        enable = 1'b1;
        tick(13);
        chk("up_cell_Y", cell_Y, 8);
        tick(16);
        chk("up2_cell_Y", cell_Y, 7);
        check_up = 1'b0; check_right = 1'b0; check_left = 1'b1;
        req(2'd2);
        tick(144);
        chk("edge_cell_X", cell_X, 0);
        chk("edge_cell_Y", cell_Y, 7);
        check_left = 1'b0;
        tick(16);
        if (TUN) chk("tunnel_cell_X", cell_X, 13);
        else begin
            chk("edge_stop_X", cell_X, 0);
            chk("edge_stop_moving", moving, 0);
        end
        chk("edge_final_sub", sub_off, 0);
        repeat (3000) begin
            Reset         = ($urandom_range(0, 199) == 0);
            enable        = ($urandom_range(0, 9) != 0);
            frame_tick    = 1'($urandom_range(0, 1));
            dir_req_valid = ($urandom_range(0, 4) == 0);
            dir_req       = 2'($urandom_range(0, 3));
            check_left    = 1'($urandom_range(0, 1));
            check_right   = 1'($urandom_range(0, 1));
            check_up      = 1'($urandom_range(0, 1));
            check_down    = 1'($urandom_range(0, 1));
            cyc();
        end
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
